prog_loader: RTL and testbench

PROG_LOADER -- requirements
Module: prog_loader

---
 rtl/prog_loader.sv | 147 ++++++++++++++
 tb/tb_prog_loader.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// Byte-stream program loader: 16-bit word count, little-endian words into instruction
// memory, then releases the core. Optional trailing checksum byte under LOADER_CHECKSUM_EN.
module prog_loader #(
  parameter logic [31:0] ADDR_BASE = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        core_reset,
  output logic        done,
  output logic        error
);

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {LEN0, LEN1, DATA, CSUM, RUN, ERR} state_e;
  localparam state_e POST_DATA = CSUM;
`else
  typedef enum logic [2:0] {LEN0, LEN1, DATA, RUN} state_e;
  localparam state_e POST_DATA = RUN;
`endif

  state_e      state_q, state_d;
  logic [15:0] count_q, count_d;
  logic [1:0]  idx_q, idx_d;
  logic [23:0] buf_q, buf_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        xfer;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]  sum_q, sum_d;
  logic [7:0]  csum_total;
`endif

  always_comb begin
    rx_ready = 1'b0;
    case (state_q)
      LEN0, LEN1: rx_ready = 1'b1;
      DATA:       rx_ready = ~we_q;
`ifdef LOADER_CHECKSUM_EN
      CSUM:       rx_ready = 1'b1;
`endif
      default:    rx_ready = 1'b0;
    endcase
  end

  assign xfer = rx_valid & rx_ready;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    idx_d   = idx_q;
    buf_d   = buf_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
`ifdef LOADER_CHECKSUM_EN
    sum_d      = sum_q;
    csum_total = sum_q + rx_data;
`endif
    case (state_q)
      LEN0: begin
        if (xfer) begin
          count_d[7:0] = rx_data;
          state_d      = LEN1;
        end
      end
      LEN1: begin
        if (xfer) begin
          count_d[15:8] = rx_data;
          state_d       = ({rx_data, count_q[7:0]} == 16'd0) ? POST_DATA : DATA;
        end
      end
      DATA: begin
        // The write cycle retires one word; count holds the words still to be written.
        if (we_q) begin
          addr_d  = addr_q + 32'd4;
          count_d = count_q - 16'd1;
          if (count_q == 16'd1) state_d = POST_DATA;
        end else if (xfer) begin
`ifdef LOADER_CHECKSUM_EN
          sum_d = sum_q + rx_data;
`endif
          idx_d = idx_q + 2'd1;
          case (idx_q)
            2'd0: buf_d[7:0]   = rx_data;
            2'd1: buf_d[15:8]  = rx_data;
            2'd2: buf_d[23:16] = rx_data;
            default: begin
              wdata_d = {rx_data, buf_q};
              we_d    = 1'b1;
            end
          endcase
        end
      end
`ifdef LOADER_CHECKSUM_EN
      CSUM: begin
        if (xfer) state_d = (csum_total == 8'h00) ? RUN : ERR;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= LEN0;
      count_q <= 16'd0;
      idx_q   <= 2'd0;
      buf_q   <= 24'd0;
      we_q    <= 1'b0;
      addr_q  <= ADDR_BASE;
      wdata_q <= 32'd0;
`ifdef LOADER_CHECKSUM_EN
      sum_q   <= 8'd0;
`endif
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      idx_q   <= idx_d;
      buf_q   <= buf_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
`ifdef LOADER_CHECKSUM_EN
      sum_q   <= sum_d;
`endif
    end
  end

  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign core_reset = (state_q != RUN);
  assign done       = (state_q == RUN);
`ifdef LOADER_CHECKSUM_EN
  assign error      = (state_q == ERR);
`else
  assign error      = 1'b0;
`endif

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: a per-cycle vector table plus multi-cycle sequences.
// Two instances (ADDR_BASE 0 and 0x100) see the same byte stream.
module tb_prog_loader;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        a_ready, a_we, a_cr, a_done, a_err;
  logic [31:0] a_addr, a_wdata;
  logic        b_ready, b_we, b_cr, b_done, b_err;
  logic [31:0] b_addr, b_wdata;

  int checks = 0;
  int failures = 0;
  int stalls = 0;

  always #5 clk = ~clk;

  prog_loader #(.ADDR_BASE(32'h0000_0000)) dut_a (
    .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_ready(a_ready), .imem_we(a_we), .imem_addr(a_addr), .imem_wdata(a_wdata),
    .core_reset(a_cr), .done(a_done), .error(a_err));

  prog_loader #(.ADDR_BASE(32'h0000_0100)) dut_b (
    .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_ready(b_ready), .imem_we(b_we), .imem_addr(b_addr), .imem_wdata(b_wdata),
    .core_reset(b_cr), .done(b_done), .error(b_err));

  logic [31:0] qa_addr[$], qa_data[$], qb_addr[$], qb_data[$];
  always @(negedge clk) begin
    if (a_we) begin qa_addr.push_back(a_addr); qa_data.push_back(a_wdata); end
    if (b_we) begin qb_addr.push_back(b_addr); qb_data.push_back(b_wdata); end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  typedef struct {
    bit rst; bit vld; logic [7:0] dat;
    bit chk; bit rdy; bit we; bit cr; bit dn; bit er;
    bit cd; logic [31:0] wd; logic [31:0] ao;
  } vec_t;
  vec_t vq[$];

  task automatic add(input bit rst, input bit vld, input logic [7:0] dat, input bit chk,
                     input bit rdy, input bit we, input bit cr, input bit dn, input bit er,
                     input bit cd, input logic [31:0] wd, input logic [31:0] ao);
    vec_t v;
    v.rst = rst; v.vld = vld; v.dat = dat; v.chk = chk; v.rdy = rdy; v.we = we;
    v.cr = cr; v.dn = dn; v.er = er; v.cd = cd; v.wd = wd; v.ao = ao;
    vq.push_back(v);
  endtask

  task automatic clear_q();
    qa_addr.delete(); qa_data.delete(); qb_addr.delete(); qb_data.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; rx_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge after the byte was accepted.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    n = 0;
    repeat (gap) begin rx_valid = 1'b0; @(negedge clk); end
    rx_valid = 1'b1; rx_data = b;
    while (!a_ready && n < 40) begin stalls++; @(negedge clk); n++; end
    if (n >= 40) begin
      checks++; failures++;
      $display("FAIL send_timeout actual=stuck expected=rx_ready");
    end
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  logic [31:0] wbuf[4];

  task automatic send_stream(input int n, input int gap, input bit bad_csum);
    logic [7:0] sum;
    logic [7:0] cs;
    logic [31:0] w;
    sum = 8'h00;
    send_byte(n[7:0], gap);
    send_byte(n[15:8], gap);
    for (int k = 0; k < n; k++) begin
      w = wbuf[k];
      for (int j = 0; j < 4; j++) begin
        sum = sum + w[j*8 +: 8];
        send_byte(w[j*8 +: 8], gap);
      end
    end
`ifdef LOADER_CHECKSUM_EN
    cs = 8'h00 - sum;
    if (bad_csum) cs = cs ^ 8'h01;
    send_byte(cs, gap);
`else
    cs = sum ^ {7'd0, bad_csum};
`endif
  endtask

  task automatic wait_done(input string nm);
    int n;
    n = 0;
    while (!a_done && n < 60) begin @(negedge clk); n++; end
    check({nm, "_done"}, {31'd0, a_done}, 32'd1);
    check({nm, "_core_reset"}, {31'd0, a_cr}, 32'd0);
    check({nm, "_b_done"}, {31'd0, b_done}, 32'd1);
    check({nm, "_rx_ready"}, {31'd0, a_ready}, 32'd0);
    check({nm, "_error"}, {31'd0, a_err}, 32'd0);
  endtask

  task automatic check_writes(input string nm, input int n);
    check({nm, "_nwr_a"}, qa_addr.size(), n);
    check({nm, "_nwr_b"}, qb_addr.size(), n);
    for (int k = 0; k < n && k < qa_addr.size() && k < qb_addr.size(); k++) begin
      check($sformatf("%s_addr_a%0d", nm, k), qa_addr[k], 32'h0 + 32'(4 * k));
      check($sformatf("%s_addr_b%0d", nm, k), qb_addr[k], 32'h100 + 32'(4 * k));
      check($sformatf("%s_data_a%0d", nm, k), qa_data[k], wbuf[k]);
      check($sformatf("%s_data_b%0d", nm, k), qb_data[k], wbuf[k]);
    end
  endtask

  initial begin
    // Single-word load, cycle by cycle.
    add(1,0,8'h00, 0, 0,0,0,0,0, 0,32'h0,32'h0);
    add(0,1,8'h01, 1, 1,0,1,0,0, 1,32'h0,32'h0);
    add(0,1,8'h00, 1, 1,0,1,0,0, 0,32'h0,32'h0);
    add(0,1,8'h13, 1, 1,0,1,0,0, 0,32'h0,32'h0);
    add(0,1,8'h00, 1, 1,0,1,0,0, 0,32'h0,32'h0);
    add(0,1,8'h10, 1, 1,0,1,0,0, 0,32'h0,32'h0);
    add(0,1,8'h00, 1, 1,0,1,0,0, 0,32'h0,32'h0);
    add(0,0,8'h00, 1, 0,1,1,0,0, 1,32'h0010_0013,32'h0);
`ifdef LOADER_CHECKSUM_EN
    add(0,1,8'hDD, 1, 1,0,1,0,0, 1,32'h0010_0013,32'h4);
`endif
    add(0,1,8'h77, 1, 0,0,0,1,0, 1,32'h0010_0013,32'h4);
    add(0,0,8'h00, 1, 0,0,0,1,0, 1,32'h0010_0013,32'h4);
    // Zero-length load.
    add(1,0,8'h00, 0, 0,0,0,0,0, 0,32'h0,32'h0);
    add(0,1,8'h00, 1, 1,0,1,0,0, 1,32'h0,32'h0);
    add(0,1,8'h00, 1, 1,0,1,0,0, 0,32'h0,32'h0);
`ifdef LOADER_CHECKSUM_EN
    add(0,1,8'h00, 1, 1,0,1,0,0, 0,32'h0,32'h0);
`endif
    add(0,0,8'h00, 1, 0,0,0,1,0, 1,32'h0,32'h0);
    add(0,0,8'h00, 1, 0,0,0,1,0, 1,32'h0,32'h0);

    foreach (vq[i]) begin
      @(negedge clk);
      if (vq[i].chk) begin
        check($sformatf("v%0d_rx_ready", i), {31'd0, a_ready}, {31'd0, vq[i].rdy});
        check($sformatf("v%0d_imem_we", i), {31'd0, a_we}, {31'd0, vq[i].we});
        check($sformatf("v%0d_core_reset", i), {31'd0, a_cr}, {31'd0, vq[i].cr});
        check($sformatf("v%0d_done", i), {31'd0, a_done}, {31'd0, vq[i].dn});
        check($sformatf("v%0d_error", i), {31'd0, a_err}, {31'd0, vq[i].er});
        check($sformatf("v%0d_b_we", i), {31'd0, b_we}, {31'd0, vq[i].we});
        if (vq[i].cd) begin
          check($sformatf("v%0d_wdata", i), a_wdata, vq[i].wd);
          check($sformatf("v%0d_addr_a", i), a_addr, vq[i].ao);
          check($sformatf("v%0d_addr_b", i), b_addr, 32'h100 + vq[i].ao);
        end
      end
      reset = vq[i].rst; rx_valid = vq[i].vld; rx_data = vq[i].dat;
    end
    check("table_total_writes", qa_addr.size(), 1);

    // Three words, rx_valid toggling every other cycle.
    do_reset(); clear_q();
    wbuf[0] = 32'hDEAD_BEEF; wbuf[1] = 32'h1234_5678; wbuf[2] = 32'h0000_0093;
    send_stream(3, 1, 1'b0);
    wait_done("gap3");
    check_writes("gap3", 3);

    // Back-to-back bytes stall across the write cycle without loss.
    do_reset(); clear_q(); stalls = 0;
    wbuf[0] = 32'hA5A5_5A5A; wbuf[1] = 32'h0102_0304;
    send_stream(2, 0, 1'b0);
    wait_done("b2b");
    check("b2b_stall_seen", {31'd0, stalls > 0}, 32'd1);
    check_writes("b2b", 2);

    // Reset mid-word with a simultaneous byte offered, then a fresh load.
    do_reset(); clear_q();
    wbuf[0] = 32'h1111_1111;
    send_byte(8'h02, 0); send_byte(8'h00, 0);
    for (int j = 0; j < 4; j++) send_byte(8'h11, 0);
    send_byte(8'h22, 0); send_byte(8'h22, 0);
    reset = 1'b1; rx_valid = 1'b1; rx_data = 8'hFF;
    @(negedge clk);
    reset = 1'b0; rx_valid = 1'b0;
    check("mid_rst_rx_ready", {31'd0, a_ready}, 32'd1);
    check("mid_rst_imem_we", {31'd0, a_we}, 32'd0);
    check("mid_rst_core_reset", {31'd0, a_cr}, 32'd1);
    check("mid_rst_done", {31'd0, a_done}, 32'd0);
    check("mid_rst_wdata", a_wdata, 32'h0);
    check("mid_rst_addr_a", a_addr, 32'h0);
    check("mid_rst_addr_b", b_addr, 32'h100);
    check("mid_rst_prior_writes", qa_addr.size(), 1);
    clear_q();
    wbuf[0] = 32'hCAFE_F00D;
    send_stream(1, 0, 1'b0);
    wait_done("fresh");
    check_writes("fresh", 1);

`ifdef LOADER_CHECKSUM_EN
    // Wrong checksum byte lands in the error state and stays there.
    do_reset(); clear_q();
    wbuf[0] = 32'h0010_0013;
    send_stream(1, 0, 1'b1);
    repeat (5) @(negedge clk);
    check("csum_error", {31'd0, a_err}, 32'd1);
    check("csum_core_reset", {31'd0, a_cr}, 32'd1);
    check("csum_done", {31'd0, a_done}, 32'd0);
    check("csum_rx_ready", {31'd0, a_ready}, 32'd0);
    check_writes("csum", 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
